vga_line_loader: RTL and testbench



---
 rtl/vga_pkg.sv | 50 +++++
 rtl/line_ram_dp.sv | 29 ++
 rtl/vga_line_loader.sv | 181 ++++++++++++++++++
 tb/tb_vga_line_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line loader and later graphic stages:
// geometry, burst size, pixel width, loader FSM encoding, test-pattern colours.
package vga_pkg;

    localparam int unsigned XSIZE     = 320;
    localparam int unsigned YSIZE     = 240;
    localparam int unsigned BURST_LEN = 8;
    localparam int unsigned PIX_W     = 16;
    localparam int unsigned ADDR_W    = 22;

    localparam logic [ADDR_W-1:0] FRAME_BASE = 22'd0;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StData
    } state_e;

    // RGB565 colour of vertical bar 0..7 (white, yellow, cyan, green, magenta, red, blue, black)
    function automatic logic [PIX_W-1:0] barColour(input logic [2:0] bar);
        logic [PIX_W-1:0] c;
        case (bar)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // line * XSIZE as a sum of shifted copies (one per set bit of XSIZE)
    function automatic logic [ADDR_W-1:0] lineOffset(input logic [9:0] line);
        logic [ADDR_W-1:0] acc;
        logic [ADDR_W-1:0] ext;
        logic [31:0]       mult;
        acc  = '0;
        ext  = ADDR_W'(line);
        mult = 32'(XSIZE);
        for (int b = 0; b < ADDR_W; b++) begin
            if (mult[0]) acc = acc + (ext << b);
            mult = mult >> 1;
        end
        return acc;
    endfunction

endpackage

// File: rtl/line_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port, independent
// addresses. No reset on the array or read register so it maps to block RAM.
module line_ram_dp #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 640,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [AddrW-1:0] wrAddr,
    input  logic [Width-1:0] wrData,
    input  logic             rdEn,
    input  logic [AddrW-1:0] rdAddr,
    output logic [Width-1:0] rdData
);

    logic [Width-1:0] mem [Depth];

    // write port
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/vga_line_loader.sv
// Fetches the next display line from SDRAM into one half of a ping-pong line
// buffer while the VGA stage reads the other half.
// Build option VGA_LINE_LOADER_TEST_PATTERN_EN: replace SDRAM fetch with an
// internally generated 8-bar colour pattern (oReq held low).
module vga_line_loader
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       iTag,
    input  logic              iEn,
    output logic [PIX_W-1:0]  oData,
    output logic              oReq,
    output logic [ADDR_W-1:0] oAddr,
    input  logic              iAck,
    input  logic              iRdValid,
    input  logic [15:0]       iRdData,
    output logic              oBusy,
    output logic              oOverrun
);

    localparam int unsigned IDX_W  = $clog2(XSIZE);
    localparam int unsigned RAM_AW = $clog2(2 * XSIZE);
    localparam int unsigned K_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XSIZE - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(BURST_LEN - 1);

    state_e           stateQ, stateD;
    logic             wrBankQ, wrBankD;
    logic [9:0]       lineQ, lineD;
    logic [IDX_W-1:0] wrIdxQ, wrIdxD;   // next word to write = burst*BURST_LEN + k
    logic [K_W-1:0]   kQ, kD;
    logic             overrunQ, overrunD;
    logic [IDX_W-1:0] rptrQ, rptrD;
    logic             rdEnQ;

    logic              tagPulse, tagOk;
    logic              wrEn;
    logic [PIX_W-1:0]  wrData;
    logic [RAM_AW-1:0] wrAddr, rdAddr;
    logic [PIX_W-1:0]  ramRdData;

    function automatic logic [RAM_AW-1:0] bankAddr(input logic bank,
                                                    input logic [IDX_W-1:0] idx);
        return bank ? RAM_AW'(XSIZE) + RAM_AW'(idx) : RAM_AW'(idx);
    endfunction

    assign tagPulse = iTag[10];
    assign tagOk    = tagPulse && (iTag[9:0] < 10'(YSIZE));

`ifdef VGA_LINE_LOADER_TEST_PATTERN_EN
    logic [2:0] barIdx;
    logic       unusedSdr;
    assign barIdx    = 3'((32'(wrIdxQ) * 32'd8) / XSIZE);
    assign unusedSdr = ^{iAck, iRdValid, iRdData};
`endif

    // state register and all sequential state
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            wrBankQ  <= 1'b0;
            lineQ    <= '0;
            wrIdxQ   <= '0;
            kQ       <= '0;
            overrunQ <= 1'b0;
            rptrQ    <= '0;
            rdEnQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            wrBankQ  <= wrBankD;
            lineQ    <= lineD;
            wrIdxQ   <= wrIdxD;
            kQ       <= kD;
            overrunQ <= overrunD;
            rptrQ    <= rptrD;
            rdEnQ    <= iEn;
        end
    end

    // next-state: an accepted tag overrides whatever the load was doing
    always_comb begin
        stateD   = stateQ;
        wrBankD  = wrBankQ;
        lineD    = lineQ;
        wrIdxD   = wrIdxQ;
        kD       = kQ;
        overrunD = overrunQ;
        wrEn     = 1'b0;
`ifdef VGA_LINE_LOADER_TEST_PATTERN_EN
        wrData   = barColour(barIdx);
`else
        wrData   = iRdData;
`endif
        if (tagOk) begin
            lineD   = iTag[9:0];
            wrBankD = ~wrBankQ;
            wrIdxD  = '0;
            kD      = '0;
            if (stateQ != StIdle) overrunD = 1'b1;
`ifdef VGA_LINE_LOADER_TEST_PATTERN_EN
            stateD  = StData;
`else
            stateD  = StReq;
`endif
        end else begin
            unique case (stateQ)
                StIdle: ;
                StReq: begin
`ifndef VGA_LINE_LOADER_TEST_PATTERN_EN
                    if (iAck) stateD = StData;
`else
                    stateD = StIdle;
`endif
                end
                StData: begin
`ifdef VGA_LINE_LOADER_TEST_PATTERN_EN
                    wrEn   = 1'b1;
                    wrIdxD = wrIdxQ + IDX_W'(1);
                    if (wrIdxQ == LAST_IDX) stateD = StIdle;
`else
                    if (iRdValid) begin
                        wrEn   = 1'b1;
                        wrIdxD = wrIdxQ + IDX_W'(1);
                        if (kQ == K_LAST) begin
                            kD     = '0;
                            stateD = (wrIdxQ == LAST_IDX) ? StIdle : StReq;
                        end else begin
                            kD = kQ + K_W'(1);
                        end
                    end
`endif
                end
                default: stateD = StIdle;
            endcase
        end
        // reset aborts immediately: nothing lands in the buffer on that edge
        if (rst) wrEn = 1'b0;
    end

    // read pointer: any tag pulse rewinds, saturates on the last pixel
    always_comb begin
        rptrD = rptrQ;
        if (tagPulse) begin
            rptrD = '0;
        end else if (iEn && (rptrQ != LAST_IDX)) begin
            rptrD = rptrQ + IDX_W'(1);
        end
    end

    // outputs and buffer addressing
    always_comb begin
`ifdef VGA_LINE_LOADER_TEST_PATTERN_EN
        oReq  = 1'b0;
`else
        oReq  = (stateQ == StReq);
`endif
        oAddr    = oReq ? (FRAME_BASE + lineOffset(lineQ) + ADDR_W'(wrIdxQ)) : '0;
        oBusy    = (stateQ != StIdle);
        oOverrun = overrunQ;
        oData    = rdEnQ ? ramRdData : '0;
        wrAddr   = bankAddr(wrBankQ, wrIdxQ);
        rdAddr   = bankAddr(~wrBankQ, rptrQ);
    end

    line_ram_dp #(
        .Width (PIX_W),
        .Depth (2 * XSIZE),
        .AddrW (RAM_AW)
    ) uLineRam (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrAddr),
        .wrData (wrData),
        .rdEn   (iEn),
        .rdAddr (rdAddr),
        .rdData (ramRdData)
    );

endmodule

// File: tb/tb_vga_line_loader.sv
// Bench for vga_line_loader: SDRAM responder with randomised latency/gaps and a
// line-level model of the ping-pong buffer (which line sits in which bank).
module tb_vga_line_loader;

    localparam int XSIZE     = 320;
    localparam int YSIZE     = 240;
    localparam int BURST_LEN = 8;

    logic        clk;
    logic        rst;
    logic [10:0] iTag;
    logic        iEn;
    logic [15:0] oData;
    logic        oReq;
    logic [21:0] oAddr;
    logic        iAck;
    logic        iRdValid;
    logic [15:0] iRdData;
    logic        oBusy;
    logic        oOverrun;

    vga_line_loader dut (
        .clk      (clk),
        .rst      (rst),
        .iTag     (iTag),
        .iEn      (iEn),
        .oData    (oData),
        .oReq     (oReq),
        .oAddr    (oAddr),
        .iAck     (iAck),
        .iRdValid (iRdValid),
        .iRdData  (iRdData),
        .oBusy    (oBusy),
        .oOverrun (oOverrun)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SDRAM frame buffer contents as a function of word address
    function automatic logic [15:0] memWord(input int unsigned a);
        logic [31:0] h;
        h = a * 32'd2654435761;
        return h[31:16] ^ a[15:0];
    endfunction

    // model: which line each bank holds, and whether it is complete
    int  bankLine [2];
    bit  bankOk   [2];
    bit  mWrBank, mBusy, mOvr;
    int  mLine, mWords, mRptr;
    // SDRAM responder
    bit  sStream, fast;
    int  sAck, sCnt, sBase, reqCount;
    bit  forceAck, forceValid;
    // expectations for the compare process
    bit          cmpOn = 0;
    bit          pKnown, eKnown, eBusy, eOvr, eReq;
    logic [15:0] pData, eData;
    logic [21:0] eAddr;

    task automatic commit();
        eBusy  = mBusy;
        eOvr   = mOvr;
        eReq   = mBusy && !sStream;
        eAddr  = 22'(mLine * XSIZE + mWords);
        eData  = pData;
        eKnown = pKnown;
    endtask

    task automatic sdramStep();
        if (!sStream) begin
            if (sAck < 0) sAck = fast ? 0 : int'($urandom_range(0, 2));
            if (sAck == 0) begin
                iAck    = 1'b1;
                sStream = 1'b1;
                sCnt    = 0;
                sAck    = -1;
                sBase   = mLine * XSIZE + mWords;
                reqCount++;
            end else begin
                sAck--;
            end
        end else if (fast || $urandom_range(0, 3) != 0) begin
            iRdValid = 1'b1;
            iRdData  = memWord(sBase + sCnt);
            sCnt++;
            mWords++;
            if (sCnt == BURST_LEN) sStream = 1'b0;
        end
    endtask

    task automatic rstCycle();
        rst = 1'b1; iTag = '0; iEn = 1'b0; iAck = 1'b0;
        iRdValid = 1'b1; iRdData = 16'hBEEF;
        mWrBank = 1'b0; mBusy = 1'b0; mOvr = 1'b0; mRptr = 0; mWords = 0;
        sStream = 1'b0; sAck = -1;
        pData = '0; pKnown = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iRdValid = 1'b0; iRdData = '0;
        commit();
    endtask

    task automatic cycle(input logic [10:0] tag, input logic en);
        bit go;
        int rb;
        go = tag[10] && (int'(tag[9:0]) < YSIZE);
        iTag = tag; iEn = en; iAck = 1'b0; iRdValid = 1'b0; iRdData = '0;
        if (!go && mBusy) sdramStep();
        if (forceAck) iAck = 1'b1;
        if (forceValid) begin iRdValid = 1'b1; iRdData = 16'hDEAD; end
        rb = mWrBank ? 0 : 1;
        if (en) begin
            pKnown = bankOk[rb];
            pData  = memWord(bankLine[rb] * XSIZE + mRptr);
            if (mRptr < XSIZE - 1) mRptr++;
        end else begin
            pKnown = 1'b1;
            pData  = '0;
        end
        if (tag[10]) mRptr = 0;
        if (go) begin
            if (mBusy) mOvr = 1'b1;
            mWrBank = !mWrBank;
            bankOk[mWrBank]   = 1'b0;
            bankLine[mWrBank] = int'(tag[9:0]);
            mLine   = int'(tag[9:0]);
            mWords  = 0;
            mBusy   = 1'b1;
            sStream = 1'b0;
            sAck    = -1;
        end else if (mBusy && mWords == XSIZE) begin
            mBusy = 1'b0;
            bankOk[mWrBank] = 1'b1;
        end
        @(posedge clk); #1;
        commit();
    endtask

    task automatic waitIdle(input bit readRandom);
        for (int n = 0; n < 4000 && mBusy; n++) cycle('0, readRandom && ($urandom_range(0, 2) != 0));
        if (mBusy) begin
            errors++; checks++;
            $display("FAIL load_timeout actual=busy required=idle");
        end
    endtask

    // every cycle: outputs against the model
    always @(negedge clk) begin
        if (cmpOn) begin
            chk("busy", 32'(oBusy), 32'(eBusy));
            chk("overrun", 32'(oOverrun), 32'(eOvr));
            chk("req", 32'(oReq), 32'(eReq));
            if (eReq) chk("addr", 32'(oAddr), 32'(eAddr));
            if (eKnown) chk("data", 32'(oData), 32'(eData));
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

`ifdef VGA_LINE_LOADER_TEST_PATTERN_EN
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic tpTick(input logic [10:0] tag, input logic en);
        iTag = tag; iEn = en;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1; iTag = '0; iEn = 1'b0; iAck = 1'b0; iRdValid = 1'b0; iRdData = '0;
        fast = 1'b0; forceAck = 1'b0; forceValid = 1'b0; reqCount = 0;
        mLine = 0; sCnt = 0; sBase = 0;
        bankLine[0] = 0; bankLine[1] = 0; bankOk[0] = 1'b0; bankOk[1] = 1'b0;
        rstCycle();
        cmpOn = 1'b1;
        rstCycle();
        chk("rst_req", 32'(oReq), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_ovr", 32'(oOverrun), 0);
        chk("rst_data", 32'(oData), 0);
        chk("rst_addr", 32'(oAddr), 0);

`ifdef VGA_LINE_LOADER_TEST_PATTERN_EN
        begin
            int busyCnt, reqHigh;
            cmpOn = 1'b0;
            busyCnt = 0; reqHigh = 0;
            tpTick(11'h400, 1'b0);
            for (int n = 0; n < 1000 && oBusy; n++) begin
                busyCnt++;
                if (oReq) reqHigh++;
                tpTick('0, 1'b0);
            end
            chk("tp_busy_cycles", 32'(busyCnt), 320);
            tpTick(11'h400, 1'b0);
            for (int i = 0; i < XSIZE; i++) begin
                tpTick('0, 1'b1);
                if (oReq) reqHigh++;
                chk("tp_pixel", 32'(oData), 32'(bars[(i * 8) / XSIZE]));
            end
            chk("tp_req_never", 32'(reqHigh), 0);
        end
`else
        // line 0: zero-latency ack, back-to-back words
        fast = 1'b1;
        cycle(11'h400, 1'b0);
        chk("l0_req", 32'(oReq), 1);
        chk("l0_addr0", 32'(oAddr), 0);
        waitIdle(1'b0);
        chk("l0_reqs", 32'(reqCount), 40);

        // line 5 loads while line 0 is streamed out (plus overstay)
        fast = 1'b0;
        cycle(11'h405, 1'b0);
        chk("l5_addr0", 32'(oAddr), 1600);
        for (int i = 0; i < XSIZE + 4; i++) begin
            cycle('0, 1'b1);
            if (i == 0) chk("l0_pix0", 32'(oData), 32'h0000);
            if (i == 1) chk("l0_pix1", 32'(oData), 32'h9E36);
        end
        cycle('0, 1'b0);
        waitIdle(1'b0);

        // out-of-range line: ignored, read pointer rewinds
        cycle(11'h4F0, 1'b0);
        chk("y240_req", 32'(oReq), 0);
        chk("y240_busy", 32'(oBusy), 0);
        chk("y240_ovr", 32'(oOverrun), 0);
        for (int i = 0; i < 10; i++) cycle('0, 1'b1);
        cycle('0, 1'b0);

        // spurious handshakes while idle must not touch the buffer
        forceAck = 1'b1; forceValid = 1'b1;
        repeat (3) cycle('0, 1'b0);
        forceAck = 1'b0; forceValid = 1'b0;
        cycle(11'h407, 1'b0);
        for (int i = 0; i < XSIZE; i++) cycle('0, $urandom_range(0, 3) != 0);
        waitIdle(1'b1);

        // overrun: second tag 100 words into a load
        cycle(11'h409, 1'b0);
        for (int n = 0; n < 2000 && mWords < 100; n++) cycle('0, 1'b0);
        cycle(11'h40B, 1'b0);
        chk("ovr_set", 32'(oOverrun), 1);
        chk("ovr_addr", 32'(oAddr), 3520);
        waitIdle(1'b0);

        // reset mid-burst while line 11 is being read
        cycle(11'h40D, 1'b0);
        for (int n = 0; n < 2000 && mWords < 50; n++) cycle('0, 1'b1);
        rstCycle();
        chk("mid_rst_req", 32'(oReq), 0);
        chk("mid_rst_busy", 32'(oBusy), 0);
        chk("mid_rst_ovr", 32'(oOverrun), 0);
        chk("mid_rst_data", 32'(oData), 0);

        // recover: load line 2 then show it with random enables
        cycle(11'h402, 1'b0);
        waitIdle(1'b1);
        cycle(11'h403, 1'b0);
        for (int i = 0; i < XSIZE; i++) cycle('0, $urandom_range(0, 4) != 0);
        waitIdle(1'b0);
`endif
        cmpOn = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
